// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer
//   Playback end of the audio-out write path. Stereo pairs are pushed through a
//   write/allowed handshake into a FIFO, popped at the start of every LRCK frame
//   and shifted MSB-first onto AUD_DACDAT in I2S format. The codec is clock
//   master: AUD_BCLK / AUD_DACLRCK are asynchronous inputs, sampled in CLOCK_50.
// Ports
//   CLOCK_50, reset                 system clock, synchronous active-high reset
//   clear_audio_out_memory          pulse: empty the FIFO and clear underrun
//   left/right_channel_audio_out    sample pair, two's complement
//   write_audio_out                 push request, taken when audio_out_allowed=1
//   audio_out_allowed               registered, FIFO has room for a pair
//   audio_out_fifo_count            registered occupancy, 0..2**FIFO_AW
//   audio_out_underrun              sticky, a frame started with the FIFO empty
//   AUD_BCLK, AUD_DACLRCK           codec clocks (LRCK 0 = left, 1 = right)
//   AUD_DACDAT                      registered serial data
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 7
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  clear_audio_out_memory,
  input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
  input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
  input  logic                  write_audio_out,
  output logic                  audio_out_allowed,
  output logic [FIFO_AW:0]      audio_out_fifo_count,
  output logic                  audio_out_underrun,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int BW    = $clog2(DATA_WIDTH + 1);
  localparam logic [FIFO_AW:0] FULL_C = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_LEFT, ST_RIGHT} state_t;

  // ---------------------------------------------------------------- sync
  logic bclk_s1_q, bclk_s2_q, bclk_h_q;
  logic lr_s1_q, lr_s2_q, lr_h_q;
  logic bclk_fall, lr_fall, lr_rise;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_s1_q <= 1'b0; bclk_s2_q <= 1'b0; bclk_h_q <= 1'b0;
      lr_s1_q   <= 1'b0; lr_s2_q   <= 1'b0; lr_h_q   <= 1'b0;
    end else begin
      bclk_s1_q <= AUD_BCLK;    bclk_s2_q <= bclk_s1_q; bclk_h_q <= bclk_s2_q;
      lr_s1_q   <= AUD_DACLRCK; lr_s2_q   <= lr_s1_q;   lr_h_q   <= lr_s2_q;
    end
  end

  assign bclk_fall = bclk_h_q & ~bclk_s2_q;
  assign lr_fall   = lr_h_q & ~lr_s2_q;
  assign lr_rise   = ~lr_h_q & lr_s2_q;

  // ---------------------------------------------------------------- state
  logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]        count_q, count_d;
  logic                    allowed_q, allowed_d;
  logic                    underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0]   sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [BW-1:0]           bit_idx_q, bit_idx_d;
  state_t                  state_q, state_d;
  logic                    dac_q, dac_d;

  logic                    push, pop, empty;
  logic [2*DATA_WIDTH-1:0] rd_data;

  assign empty   = (count_q == '0);
  // clear discards a coincident push and suppresses a coincident pop
  assign push    = write_audio_out & allowed_q & ~clear_audio_out_memory;
  assign pop     = lr_fall & ~empty & ~clear_audio_out_memory;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{(FIFO_AW-1){1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{(FIFO_AW-1){1'b0}}, pop};
    count_d    = count_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    underrun_d = underrun_q | (lr_fall & empty);
    if (clear_audio_out_memory) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      underrun_d = 1'b0;
    end
    allowed_d = (count_d != FULL_C);
  end

  // Frame/slot sequencing and serializer. The bclk_fall that coincides with an
  // LRCK edge emits the I2S delay bit (0); data starts on the following fall.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    sh_l_d    = sh_l_q;
    sh_r_d    = sh_r_q;
    dac_d     = dac_q;

    if (lr_fall) begin
      state_d   = ST_LEFT;
      bit_idx_d = '0;
      sh_l_d    = pop ? rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      sh_r_d    = pop ? rd_data[DATA_WIDTH-1:0]            : '0;
    end else if (lr_rise && state_q != ST_IDLE) begin
      state_d   = ST_RIGHT;
      bit_idx_d = '0;
    end

    if (bclk_fall) begin
      dac_d = 1'b0;
      if (!lr_fall && !lr_rise && state_q != ST_IDLE &&
          bit_idx_q < BW'(DATA_WIDTH)) begin
        bit_idx_d = bit_idx_q + BW'(1);
        if (state_q == ST_LEFT) begin
          dac_d  = sh_l_q[DATA_WIDTH-1];
          sh_l_d = {sh_l_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
          dac_d  = sh_r_q[DATA_WIDTH-1];
          sh_r_d = {sh_r_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      allowed_q  <= 1'b0;
      underrun_q <= 1'b0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
      bit_idx_q  <= '0;
      state_q    <= ST_IDLE;
      dac_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      allowed_q  <= allowed_d;
      underrun_q <= underrun_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
      bit_idx_q  <= bit_idx_d;
      state_q    <= state_d;
      dac_q      <= dac_d;
    end
  end

  // storage only, contents are don't-care while empty
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= {left_channel_audio_out, right_channel_audio_out};
  end

  assign audio_out_allowed    = allowed_q;
  assign audio_out_fifo_count = count_q;
  assign audio_out_underrun   = underrun_q;
  assign AUD_DACDAT           = dac_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
module tb_audio_dac_serializer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] left_in = '0, right_in = '0;
  logic        write = 1'b0;
  logic        allowed, underrun, dacdat;
  logic [7:0]  count;
  logic        bclk = 1'b1, lrck = 1'b1;

  audio_dac_serializer #(.DATA_WIDTH(32), .FIFO_AW(7)) dut (
    .CLOCK_50(clk), .reset(reset), .clear_audio_out_memory(clear),
    .left_channel_audio_out(left_in), .right_channel_audio_out(right_in),
    .write_audio_out(write), .audio_out_allowed(allowed),
    .audio_out_fifo_count(count), .audio_out_underrun(underrun),
    .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dacdat)
  );

  always #5 clk = ~clk;

  // reference model
  logic [63:0] mfifo[$];
  bit          exp_bits[$];
  logic        m_underrun = 1'b0;
  int          vecs = 0, errs = 0;

  task automatic chk_status(input string name);
    vecs++;
    if (count !== 8'(mfifo.size())) begin
      errs++; $display("FAIL %s count: got %0d want %0d", name, count, mfifo.size());
    end
    vecs++;
    if (allowed !== (mfifo.size() < 128)) begin
      errs++; $display("FAIL %s allowed: got %b want %b", name, allowed, mfifo.size() < 128);
    end
    vecs++;
    if (underrun !== m_underrun) begin
      errs++; $display("FAIL %s underrun: got %b want %b", name, underrun, m_underrun);
    end
  endtask

  // one BCLK falling edge (optionally with an LRCK level), optional push that
  // lands in the same CLOCK_50 cycle as the synchronized edges
  task automatic fall(input logic lr, input bit do_push, input logic [31:0] pl, input logic [31:0] pr);
    bit e;
    @(negedge clk); bclk = 1'b0; lrck = lr;
    @(negedge clk);
    @(negedge clk);
    if (do_push) begin
      write = 1'b1; left_in = pl; right_in = pr;
      if (mfifo.size() < 128) mfifo.push_back({pl, pr});
    end
    @(negedge clk); write = 1'b0;
    @(negedge clk);
    e = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'b0;
    vecs++;
    if (dacdat !== e) begin
      errs++; $display("FAIL dacdat bit: got %b want %b at %0t", dacdat, e, $time);
    end
    bclk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_frame(input int nl, input int nr);
    logic [63:0] w;
    if (mfifo.size() > 0) w = mfifo.pop_front();
    else begin w = '0; m_underrun = 1'b1; end
    exp_bits.push_back(1'b0);
    for (int i = 0; i < nl - 1; i++) exp_bits.push_back(i < 32 ? w[63-i] : 1'b0);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < nr - 1; i++) exp_bits.push_back(i < 32 ? w[31-i] : 1'b0);
  endtask

  task automatic frame(input int nl, input int nr, input bit push_edge,
                       input logic [31:0] pl, input logic [31:0] pr);
    load_frame(nl, nr);
    fall(1'b0, push_edge, pl, pr);
    for (int i = 1; i < nl; i++) fall(1'b0, 0, '0, '0);
    fall(1'b1, 0, '0, '0);
    for (int i = 1; i < nr; i++) fall(1'b1, 0, '0, '0);
    chk_status("frame_end");
  endtask

  task automatic push_burst(input int n);
    logic [31:0] l, r;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vecs++;
      if (allowed !== (mfifo.size() < 128)) begin
        errs++; $display("FAIL burst allowed[%0d]: got %b want %b", i, allowed, mfifo.size() < 128);
      end
      l = $urandom; r = $urandom;
      write = 1'b1; left_in = l; right_in = r;
      if (mfifo.size() < 128) mfifo.push_back({l, r});
    end
    @(negedge clk); write = 1'b0;
  endtask

  task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
    @(negedge clk); write = 1'b1; left_in = l; right_in = r;
    if (mfifo.size() < 128) mfifo.push_back({l, r});
    @(negedge clk); write = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    mfifo.delete(); m_underrun = 1'b0;
    chk_status("clear");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if (dacdat !== 1'b0 || allowed !== 1'b0 || count !== 8'd0 || underrun !== 1'b0) begin
        errs++; $display("FAIL reset: dac=%b allowed=%b count=%0d underrun=%b want 0 0 0 0",
                         dacdat, allowed, count, underrun);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    vecs++;
    if (allowed !== 1'b1) begin
      errs++; $display("FAIL reset_release allowed: got %b want 1", allowed);
    end
  endtask

  task automatic test_serialize();
    push_pair(32'hA500_0001, 32'h8000_0001);
    chk_status("pre_frame");
    frame(33, 33, 0, '0, '0);
  endtask

  task automatic test_full();
    push_burst(129);
    chk_status("full");
    do_clear();
  endtask

  task automatic test_underrun();
    frame(33, 33, 0, '0, '0);
    do_clear();
  endtask

  task automatic test_push_at_pop();
    push_pair(32'h1234_5678, 32'h9ABC_DEF0);
    frame(33, 33, 1, 32'h0F0F_00FF, 32'hF000_000F);
    frame(33, 33, 0, '0, '0);
  endtask

  task automatic test_short_slot();
    push_pair(32'hFFFF_FFFF, 32'hC000_0003);
    frame(32, 20, 0, '0, '0);
  endtask

  task automatic test_back_to_back();
    push_burst(3);
    repeat (3) frame(33, 33, 0, '0, '0);
  endtask

  task automatic test_reset_mid_slot();
    push_pair(32'hDEAD_BEEF, 32'h0BAD_F00D);
    load_frame(33, 33);
    fall(1'b0, 0, '0, '0);
    for (int i = 0; i < 10; i++) fall(1'b0, 0, '0, '0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    vecs++;
    if (dacdat !== 1'b0) begin
      errs++; $display("FAIL midreset dacdat: got %b want 0", dacdat);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mfifo.delete(); exp_bits.delete(); m_underrun = 1'b0;
    @(negedge clk);
    chk_status("midreset");
    // idle: LRCK low, BCLK running, then LRCK rises while idle
    repeat (3) fall(1'b0, 0, '0, '0);
    push_pair(32'h7FFF_0000, 32'h0000_FFFE);
    fall(1'b1, 0, '0, '0);
    fall(1'b1, 0, '0, '0);
    frame(33, 33, 0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_serialize();
    test_full();
    test_underrun();
    test_push_at_pop();
    test_short_slot();
    test_back_to_back();
    test_reset_mid_slot();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
